// File: rtl/pac_motion_ctrl.sv
// pac_motion_ctrl: tile movement controller for the Pacman sprite.
// Optional feature: define PAC_TUNNEL_EN for x-edge wraparound tunnels.
module pac_motion_ctrl #(
    parameter int GRID_W  = 28,
    parameter int GRID_H  = 31,
    parameter int START_X = 13,
    parameter int START_Y = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] btn_dir,
    output logic       wq_valid,
    output logic [4:0] wq_x,
    output logic [4:0] wq_y,
    input  logic       wq_ready,
    input  logic       wq_wall,
    output logic [4:0] pos_x,
    output logic [4:0] pos_y,
    output logic [3:0] direction,
    output logic       moving,
    output logic       busy,
    output logic       overrun
);

    localparam logic [4:0] XMAX = 5'(GRID_W - 1);
    localparam logic [4:0] YMAX = 5'(GRID_H - 1);
    localparam logic [4:0] SX   = 5'(START_X);
    localparam logic [4:0] SY   = 5'(START_Y);

    typedef enum logic [1:0] {IDLE, Q_REQ, Q_CUR, MOVE} state_t;

    state_t     state, state_n;
    logic [3:0] req_dir;
    logic [3:0] qdir, qdir_n;
    logic [3:0] req_eff;
    logic       btn_ok;
    logic [4:0] nb_x, nb_y;
    logic       nb_blk;
    logic       issue, stop;
    logic       hit_free, hit_wall;

    assign btn_ok  = (btn_dir != 4'b0) && ((btn_dir & (btn_dir - 4'd1)) == 4'b0);
    assign req_eff = btn_ok ? btn_dir : req_dir;
    assign busy    = (state != IDLE);

    // neighbour tile of pos in the direction currently being tried
    always_comb begin
        nb_x   = pos_x;
        nb_y   = pos_y;
        nb_blk = 1'b0;
        unique case (1'b1)
            qdir[3]: begin
                if (pos_x == 5'd0) begin
`ifdef PAC_TUNNEL_EN
                    nb_x = XMAX;
`else
                    nb_blk = 1'b1;
`endif
                end else begin
                    nb_x = pos_x - 5'd1;
                end
            end
            qdir[2]: begin
                if (pos_y == 5'd0) nb_blk = 1'b1;
                else               nb_y   = pos_y - 5'd1;
            end
            qdir[1]: begin
                if (pos_x == XMAX) begin
`ifdef PAC_TUNNEL_EN
                    nb_x = 5'd0;
`else
                    nb_blk = 1'b1;
`endif
                end else begin
                    nb_x = pos_x + 5'd1;
                end
            end
            qdir[0]: begin
                if (pos_y == YMAX) nb_blk = 1'b1;
                else               nb_y   = pos_y + 5'd1;
            end
            default: nb_blk = 1'b1;
        endcase
    end

    // query outcome: internal block resolves before any handshake
    always_comb begin
        hit_free = wq_valid && wq_ready && !wq_wall;
        hit_wall = wq_valid ? (wq_ready && wq_wall) : nb_blk;
    end

    // next-state and control strobes
    always_comb begin
        state_n = state;
        qdir_n  = qdir;
        issue   = 1'b0;
        stop    = 1'b0;
        unique case (state)
            IDLE: begin
                if (tick) begin
                    if (req_eff != 4'b0) begin
                        state_n = Q_REQ;
                        qdir_n  = req_eff;
                    end else if (direction != 4'b0) begin
                        state_n = Q_CUR;
                        qdir_n  = direction;
                    end else begin
                        stop = 1'b1;
                    end
                end
            end
            Q_REQ, Q_CUR: begin
                issue = !wq_valid && !nb_blk;
                if (hit_free) begin
                    state_n = MOVE;
                end else if (hit_wall) begin
                    if (state == Q_REQ && direction != 4'b0 &&
                        direction != qdir) begin
                        state_n = Q_CUR;
                        qdir_n  = direction;
                    end else begin
                        state_n = IDLE;
                        stop    = 1'b1;
                    end
                end
            end
            MOVE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            qdir  <= 4'b0;
        end else begin
            state <= state_n;
            qdir  <= qdir_n;
        end
    end

    // request buffer, query port, position and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            req_dir   <= 4'b0;
            wq_valid  <= 1'b0;
            wq_x      <= 5'd0;
            wq_y      <= 5'd0;
            pos_x     <= SX;
            pos_y     <= SY;
            direction <= 4'b0;
            moving    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (btn_ok) req_dir <= btn_dir;
            if (tick && busy) overrun <= 1'b1;
            if (issue) begin
                wq_valid <= 1'b1;
                wq_x     <= nb_x;
                wq_y     <= nb_y;
            end else if (wq_valid && wq_ready) begin
                wq_valid <= 1'b0;
            end
            if (stop) moving <= 1'b0;
            if (state == MOVE) begin
                pos_x     <= nb_x;
                pos_y     <= nb_y;
                direction <= qdir;
                moving    <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pac_motion_ctrl.md
# pac_motion_ctrl

Tile-level movement controller for the Pacman sprite. It buffers the player's direction request and, on each movement tick, queries the maze for walls through a valid/ready handshake. It then commits the new tile position and the one-hot `direction` code that drives the Pacman sprite ROM. It sits between the input decoder, the maze map, and the sprite renderer.

## Interface
Parameters:
- `GRID_W`, 28, maze width in tiles
- `GRID_H`, 31, maze height in tiles
- `START_X`, 13, reset tile column
- `START_Y`, 23, reset tile row

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `tick` in 1: single-cycle movement strobe.
- `btn_dir` in 4: one-hot request, L=4'b1000, U=4'b0100, R=4'b0010, D=4'b0001.
- `wq_valid` out 1: wall query valid.
- `wq_x` out 5: queried tile column.
- `wq_y` out 5: queried tile row.
- `wq_ready` in 1: map accepts the query this cycle.
- `wq_wall` in 1: wall flag, valid when `wq_ready`=1.
- `pos_x` out 5: current tile column.
- `pos_y` out 5: current tile row.
- `direction` out 4: one-hot heading for the sprite ROM; 4'b0000 means none (default sprite).
- `moving` out 1: the last tick produced a move.
- `busy` out 1: FSM not in IDLE.
- `overrun` out 1: sticky; a tick arrived while busy.

## Operation
- Request register `req_dir` (4 bits):
  - Loads `btn_dir` on any cycle where `btn_dir` is exactly one-hot.
  - Zero or multi-hot values are ignored.
  - Holds its value until overwritten; cleared only by reset.
- FSM states: IDLE, Q_REQ, Q_CUR, MOVE.
- IDLE:
  - On `tick`: go to Q_REQ if `req_dir`≠0; else Q_CUR if `direction`≠0; else stay in IDLE with `moving`←0.
- Q_REQ: query the neighbour tile in `req_dir`.
  - Free → MOVE with `sel`=req.
  - Wall → Q_CUR if `direction`≠0 and `direction`≠`req_dir`; else IDLE with `moving`←0.
- Q_CUR: query the neighbour tile in `direction`.
  - Free → MOVE with `sel`=cur.
  - Wall → IDLE with `moving`←0.
- MOVE (one cycle): `pos` ← neighbour; `moving`←1; if `sel`=req then `direction`←`req_dir`; go to IDLE.
- Neighbour arithmetic:
  - L: x−1. R: x+1. U: y−1. D: y+1.
  - `y`=0 with U, or `y`=GRID_H−1 with D: blocked internally. No query is issued and the FSM treats it as a wall in zero handshake cycles.
  - `x` edges are governed by Configuration.
- `direction` never changes on a blocked tick. `pos` changes only in MOVE.
- `tick` while `busy`=1: dropped, `overrun`←1 (sticky until reset).
- Reset values:
  - `pos_x`=START_X, `pos_y`=START_Y
  - `direction`=0, `req_dir`=0
  - `moving`=0, `busy`=0, `overrun`=0
  - `wq_valid`=0, `wq_x`=0, `wq_y`=0
  - FSM in IDLE.
- Reset asserted mid-query: all of the above apply at the next edge. The pending query is abandoned and `wq_valid` is 0 the following cycle.

## Timing
- `wq_valid`, `wq_x` and `wq_y` are registered. They assert the cycle after entering Q_REQ/Q_CUR and stay stable until a cycle with `wq_ready`=1.
- `wq_wall` is sampled on that same edge. `wq_valid` deasserts on the next cycle.
- The map may hold `wq_ready` low indefinitely; the FSM waits with no timeout.
- Best case (ready immediately, free): `tick` at cycle 0; `pos`/`direction` updated and visible at cycle 4; `busy` low at cycle 4.
- Fallback path (requested direction walled, current free): add 2 cycles per extra query.
- `tick` in the same cycle as a `btn_dir` change: the new request is used; the register load wins before the IDLE decision.

## Configuration
- `PAC_TUNNEL_EN` defined:
  - `x`=0 with L queries and moves to `x`=GRID_W−1.
  - `x`=GRID_W−1 with R queries and moves to `x`=0.
- `PAC_TUNNEL_EN` undefined: both `x` edges are blocked internally like the `y` edges, with no query issued.

## Test plan
- After reset: `pos`=(13,23), `direction`=0. `btn_dir`=R, `tick`, `wq_ready`=1, `wall`=0 → query (14,23); `pos`=(14,23), `direction`=4'b0010, `moving`=1.
- Heading R, `req_dir`=U. U tile walled, R tile free → two queries, (x,22) then (x+1,23); `pos_x`+1, `direction` stays 4'b0010.
- Both directions walled → `pos` unchanged, `moving`=0, `direction` unchanged. `btn_dir`=4'b0110 → `req_dir` unchanged.
- `wq_ready` held low for 10 cycles → `wq_valid`/`wq_x`/`wq_y` stable throughout. A `tick` during the wait sets `overrun`=1, and `overrun` stays 1.
- `pos`=(0,14), request L:
  - With `PAC_TUNNEL_EN`: query (27,14), `pos` becomes (27,14).
  - Without `PAC_TUNNEL_EN`: no `wq_valid`, `pos` stays (0,14).
- `rst` asserted while `wq_valid`=1 → next cycle `wq_valid`=0, `pos`=(13,23), `busy`=0, `overrun`=0.
